// File: rtl/awg_seq_pkg.sv
// Shared types for the AWG preset sequencer.
// Entry layout: {wave, freq, dwell}, 38 bits.
package awg_seq_pkg;

    localparam int FREQ_W  = 20;
    localparam int WAVE_W  = 2;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT_WRAP
    } state_t;

    typedef struct packed {
        logic [WAVE_W-1:0]  wave;
        logic [FREQ_W-1:0]  freq;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    // Dwell of 0 ms plays as 1 ms.
    function automatic logic [DWELL_W-1:0] dwell_eff(
        input logic [DWELL_W-1:0] d
    );
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

endpackage

// File: rtl/awg_seq_table.sv
// Sequencer entry RAM: sync write, registered read-before-write port.
// Per-entry valid bits make the table read as zero after reset.
module awg_seq_table
    import awg_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  entry_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_data
);

    entry_t             mem [DEPTH];
    logic [DEPTH-1:0]   vld;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld     <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en)
                vld[wr_addr] <= 1'b1;
            if (rd_en)
                rd_data <= vld[rd_addr] ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/awg_sequencer.sv
// AWG preset sequencer: plays table entries for their dwell time.
// AWG_SEQ_WRAP_SYNC_EN: defer entry changes to a phase-accumulator wrap.
module awg_sequencer
    import awg_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int MS_DIV = 100000,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WAVE_W-1:0] wr_wave,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [AW-1:0]     last_idx,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              phase_msb,
    output logic [FREQ_W-1:0] freq_out,
    output logic [WAVE_W-1:0] wave_sel,
    output logic [AW-1:0]     cur_idx,
    output logic              busy,
    output logic              step_pulse,
    output logic              done
);

    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);

    state_t              state;
    logic [AW-1:0]       idx;
    logic [PW-1:0]       pre;
    logic [DWELL_W-1:0]  cnt;
    entry_t              entry_q;
    logic                rd_en;
    logic                more;
    logic [AW-1:0]       nxt_idx;
    logic                wrap_wait;
    logic                wrap;
    logic [DWELL_W-1:0]  dwell_last;

    awg_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_wave, wr_freq, wr_dwell}),
        .rd_en   (rd_en),
        .rd_addr (idx),
        .rd_data (entry_q)
    );

    assign freq_out = entry_q.freq;
    assign wave_sel = entry_q.wave;
    assign rd_en    = (state == S_LOAD) && !stop;

`ifdef AWG_SEQ_WRAP_SYNC_EN
    logic phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase_q <= 1'b0;
        else
            phase_q <= phase_msb;
    end

    assign wrap      = phase_q & ~phase_msb;
    assign wrap_wait = (entry_q.freq != '0);
`else
    logic unused_phase;

    assign unused_phase = phase_msb;
    assign wrap         = 1'b0;
    assign wrap_wait    = 1'b0;
`endif

    // last_idx below the current index makes this entry the last one.
    always_comb begin
        more       = (idx < last_idx) || loop_en;
        nxt_idx    = (idx < last_idx) ? idx + AW'(1) : '0;
        dwell_last = dwell_eff(entry_q.dwell) - DWELL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            cur_idx    <= '0;
            pre        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_LOAD;
                            idx   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        cur_idx    <= idx;
                        step_pulse <= 1'b1;
                        pre        <= '0;
                        cnt        <= '0;
                        state      <= S_RUN;
                    end
                    S_RUN: begin
                        if (pre != PRE_LAST) begin
                            pre <= pre + PW'(1);
                        end else begin
                            pre <= '0;
                            if (cnt != dwell_last) begin
                                cnt <= cnt + DWELL_W'(1);
                            end else if (wrap_wait) begin
                                state <= S_WAIT_WRAP;
                            end else if (more) begin
                                idx   <= nxt_idx;
                                state <= S_LOAD;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_WRAP: begin
                        if (wrap) begin
                            if (more) begin
                                idx   <= nxt_idx;
                                state <= S_LOAD;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_awg_sequencer.sv
// Directed bench for awg_sequencer with MS_DIV=10.
// Define AWG_SEQ_WRAP_SYNC_EN to also exercise phase-wrap sync.
module tb_awg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [1:0]  wr_wave;
    logic [19:0] wr_freq;
    logic [15:0] wr_dwell;
    logic [2:0]  last_idx;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        phase_msb;
    logic [19:0] freq_out;
    logic [1:0]  wave_sel;
    logic [2:0]  cur_idx;
    logic        busy;
    logic        step_pulse;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;

    awg_sequencer #(
        .DEPTH  (8),
        .MS_DIV (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_wave    (wr_wave),
        .wr_freq    (wr_freq),
        .wr_dwell   (wr_dwell),
        .last_idx   (last_idx),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .phase_msb  (phase_msb),
        .freq_out   (freq_out),
        .wave_sel   (wave_sel),
        .cur_idx    (cur_idx),
        .busy       (busy),
        .step_pulse (step_pulse),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] w,
                      input logic [19:0] f, input logic [15:0] d);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_wave  = w;
        wr_freq  = f;
        wr_dwell = d;
        cyc(1);
        wr_en    = 1'b0;
    endtask

    task automatic load_std;
        wr(3'd0, 2'b00, 20'd1000, 16'd2);
        wr(3'd1, 2'b01, 20'd5000, 16'd1);
        wr(3'd2, 2'b11, 20'd20, 16'd3);
        last_idx = 3'd2;
        loop_en  = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++; if (freq_out !== 20'd0) $display("FAIL rst_freq got %0d exp 0", freq_out); else pass_cnt++;
        total_cnt++; if (wave_sel !== 2'd0) $display("FAIL rst_wave got %0d exp 0", wave_sel); else pass_cnt++;
        total_cnt++; if (cur_idx !== 3'd0) $display("FAIL rst_idx got %0d exp 0", cur_idx); else pass_cnt++;
        total_cnt++; if ({busy, step_pulse, done} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {busy, step_pulse, done}); else pass_cnt++;
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_one_shot;
        load_std();
        pulse_start();
        total_cnt++; if ({busy, step_pulse} !== 2'b10) $display("FAIL os_t1 got %b exp 10", {busy, step_pulse}); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out, wave_sel, cur_idx} !== {1'b1, 20'd1000, 2'd0, 3'd0}) $display("FAIL os_t2 got sp=%b f=%0d w=%0d i=%0d exp 1/1000/0/0", step_pulse, freq_out, wave_sel, cur_idx); else pass_cnt++;
        cyc(20);
        total_cnt++; if (step_pulse !== 1'b0) $display("FAIL os_t22 got %b exp 0", step_pulse); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out, wave_sel, cur_idx} !== {1'b1, 20'd5000, 2'd1, 3'd1}) $display("FAIL os_t23 got sp=%b f=%0d w=%0d i=%0d exp 1/5000/1/1", step_pulse, freq_out, wave_sel, cur_idx); else pass_cnt++;
        cyc(11);
        total_cnt++; if ({step_pulse, freq_out, wave_sel, cur_idx} !== {1'b1, 20'd20, 2'd3, 3'd2}) $display("FAIL os_t34 got sp=%b f=%0d w=%0d i=%0d exp 1/20/3/2", step_pulse, freq_out, wave_sel, cur_idx); else pass_cnt++;
        cyc(29);
        total_cnt++; if ({busy, done} !== 2'b10) $display("FAIL os_t63 got %b exp 10", {busy, done}); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({busy, done} !== 2'b01) $display("FAIL os_t64 got %b exp 01", {busy, done}); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({done, freq_out} !== {1'b0, 20'd20}) $display("FAIL os_hold got d=%b f=%0d exp 0/20", done, freq_out); else pass_cnt++;
    endtask

    task automatic test_loop;
        loop_en = 1'b1;
        pulse_start();
        cyc(63);
        total_cnt++; if ({busy, done} !== 2'b10) $display("FAIL lp_t64 got %b exp 10", {busy, done}); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out, cur_idx} !== {1'b1, 20'd1000, 3'd0}) $display("FAIL lp_t65 got sp=%b f=%0d i=%0d exp 1/1000/0", step_pulse, freq_out, cur_idx); else pass_cnt++;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL lp_stop got %b exp 00", {busy, done}); else pass_cnt++;
        loop_en = 1'b0;
    endtask

    task automatic test_stop;
        pulse_start();
        cyc(24);
        total_cnt++; if (freq_out !== 20'd5000) $display("FAIL st_run got %0d exp 5000", freq_out); else pass_cnt++;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        total_cnt++; if ({busy, done, freq_out} !== {2'b00, 20'd5000}) $display("FAIL st_idle got b=%b d=%b f=%0d exp 0/0/5000", busy, done, freq_out); else pass_cnt++;
        cyc(1);
        total_cnt++; if (done !== 1'b0) $display("FAIL st_nodone got %b exp 0", done); else pass_cnt++;
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL st_both got %b exp 0", busy); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({busy, step_pulse} !== 2'b00) $display("FAIL st_both2 got %b exp 00", {busy, step_pulse}); else pass_cnt++;
    endtask

    task automatic test_dwell_zero_write;
        wr(3'd0, 2'b10, 20'd300, 16'd0);
        last_idx = 3'd1;
        pulse_start();
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out, wave_sel} !== {1'b1, 20'd300, 2'd2}) $display("FAIL dz_t2 got sp=%b f=%0d w=%0d exp 1/300/2", step_pulse, freq_out, wave_sel); else pass_cnt++;
        cyc(3);
        wr(3'd1, 2'b11, 20'd777, 16'd1);
        cyc(6);
        total_cnt++; if ({step_pulse, freq_out} !== {1'b0, 20'd300}) $display("FAIL dz_t12 got sp=%b f=%0d exp 0/300", step_pulse, freq_out); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out, wave_sel, cur_idx} !== {1'b1, 20'd777, 2'd3, 3'd1}) $display("FAIL dz_t13 got sp=%b f=%0d w=%0d i=%0d exp 1/777/3/1", step_pulse, freq_out, wave_sel, cur_idx); else pass_cnt++;
        cyc(10);
        total_cnt++; if ({busy, done} !== 2'b01) $display("FAIL dz_done got %b exp 01", {busy, done}); else pass_cnt++;
    endtask

`ifdef AWG_SEQ_WRAP_SYNC_EN
    task automatic test_wrap_sync;
        wr(3'd0, 2'b00, 20'd1000, 16'd2);
        wr(3'd1, 2'b01, 20'd5000, 16'd1);
        wr(3'd2, 2'b00, 20'd0, 16'd1);
        last_idx  = 3'd2;
        phase_msb = 1'b1;
        cyc(1);
        pulse_start();
        cyc(21);
        total_cnt++; if ({busy, step_pulse, freq_out} !== {2'b10, 20'd1000}) $display("FAIL ws_wait0 got b=%b sp=%b f=%0d exp 1/0/1000", busy, step_pulse, freq_out); else pass_cnt++;
        cyc(8);
        phase_msb = 1'b0;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out} !== {1'b0, 20'd1000}) $display("FAIL ws_t31 got sp=%b f=%0d exp 0/1000", step_pulse, freq_out); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out} !== {1'b1, 20'd5000}) $display("FAIL ws_t32 got sp=%b f=%0d exp 1/5000", step_pulse, freq_out); else pass_cnt++;
        phase_msb = 1'b1;
        cyc(13);
        phase_msb = 1'b0;
        cyc(1);
        total_cnt++; if (step_pulse !== 1'b0) $display("FAIL ws_t46 got %b exp 0", step_pulse); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, freq_out} !== {1'b1, 20'd0}) $display("FAIL ws_t47 got sp=%b f=%0d exp 1/0", step_pulse, freq_out); else pass_cnt++;
        phase_msb = 1'b1;
        cyc(10);
        total_cnt++; if ({busy, done} !== 2'b01) $display("FAIL ws_f0done got %b exp 01", {busy, done}); else pass_cnt++;
        phase_msb = 1'b0;
    endtask
`endif

    task automatic test_async_reset;
        load_std();
        pulse_start();
        cyc(4);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({freq_out, wave_sel, cur_idx} !== 25'd0) $display("FAIL ar_outs got f=%0d w=%0d i=%0d exp 0/0/0", freq_out, wave_sel, cur_idx); else pass_cnt++;
        total_cnt++; if ({busy, step_pulse, done} !== 3'b000) $display("FAIL ar_flags got %b exp 000", {busy, step_pulse, done}); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);
        pulse_start();
        total_cnt++; if (busy !== 1'b1) $display("FAIL ar_t1 got %b exp 1", busy); else pass_cnt++;
        cyc(1);
        total_cnt++; if ({step_pulse, cur_idx, freq_out} !== {1'b1, 3'd0, 20'd0}) $display("FAIL ar_t2 got sp=%b i=%0d f=%0d exp 1/0/0", step_pulse, cur_idx, freq_out); else pass_cnt++;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_wave   = '0;
        wr_freq   = '0;
        wr_dwell  = '0;
        last_idx  = '0;
        loop_en   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        phase_msb = 1'b0;
        cyc(2);
        test_reset();
        test_one_shot();
        test_loop();
        test_stop();
        test_dwell_zero_write();
`ifdef AWG_SEQ_WRAP_SYNC_EN
        test_wrap_sync();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
